pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush/bubble sequencer for the 5-stage pipe. Drives the stage-register
//  enables (fetch, decode, ALU, MEM), the decode/ALU flushes and the decode NOP-injection mux.
//  Inputs: cache block signals, EX load-use info, branch resolution and decode TLB_WRITE.
//  Replaces the ad-hoc enable generation inside control with one FSM.
// PARAMETERS
//  NOP_WORD          32'h0000_0000  instruction word driven on inject_nop
//  TLB_DRAIN_CYCLES  2              fetch-hold cycles after a TLB write leaves decode (>=1)
//  CNT_W             32             perf counter width (PIPE_HAZARD_PERF_EN only)
// PORTS
//  clk                    in   1   clock, rising edge
//  reset                  in   1   asynchronous reset, active-low
//  id_regA, id_regB       in   5   source regs of the instruction in decode
//  id_uses_regB           in   1   decode instruction reads regB (not immediate)
//  id_tlb_write           in   1   decode instruction is a TLB write
//  ex_mem_r_en, ex_wb_en  in   1   ALU-stage instruction is a load / writes back
//  ex_regD                in   5   ALU-stage destination reg
//  branch_taken           in   1   branch resolved taken in ALU stage this cycle
//  block_pipe_instr_cache in   1   I-cache miss in progress
//  block_pipe_data_cache  in   1   D-cache miss in progress
//  en_reg_fetch, en_reg_decode, en_reg_alu, en_reg_mem  out 1  stage-register enables
//  flush_decode, flush_alu     out 1    clear decode / ALU stage registers
//  inject_nop                  out 32   NOP_WORD, constant
//  injecting_nop               out 1    decode selects inject_nop instead of fetched word
//  hz_state                    out 3    current FSM state (debug)
// BEHAVIOUR
//  - Outputs are combinational from the registered state and current inputs. The state and
//    drain counter are the only flops. reset low => state RUN, counter 0. While reset is low:
//    all en_*=0, flush_*=1, injecting_nop=0.
//  - States: RUN=0, IC_WAIT=1, DC_WAIT=2, TLB_DRAIN=3. Encodings 4-7 are illegal and go to RUN.
//  - Priority, highest first: DC miss > branch_taken > TLB drain > I-cache miss > load-use.
//  - DC miss (any state): all en_*=0, flushes 0. Enter DC_WAIT; stay while block=1.
//    On the block 1->0 cycle, issue RUN outputs and go to RUN.
//  - branch_taken in RUN/IC_WAIT: flush_decode=flush_alu=1, all en_*=1, injecting_nop=0,
//    next state RUN. The pending I-miss stays with the fetch unit.
//  - id_tlb_write in RUN, no higher event: normal advance, load counter=TLB_DRAIN_CYCLES,
//    go to TLB_DRAIN. In TLB_DRAIN: en_reg_fetch=0, en_reg_decode=1 with injecting_nop=1,
//    ALU/MEM enabled, counter decrements each cycle; at counter==1 go to RUN.
//  - I-miss in RUN: en_reg_fetch=0, injecting_nop=1, en_reg_decode/alu/mem=1, go to IC_WAIT.
//    Stay while block=1; the first cycle with block=0 gives RUN outputs.
//  - Load-use (RUN only): ex_mem_r_en & ex_wb_en & ex_regD!=0 &
//    (ex_regD==id_regA | id_uses_regB & ex_regD==id_regB). Stall for exactly one cycle:
//    en_reg_fetch=0, injecting_nop=1, en_reg_decode=1. No state change; the bubble clears it.
//  - RUN, no event: all en_*=1, flushes 0, injecting_nop=0.
//  - reset low mid-drain or mid-wait aborts immediately to RUN and discards the counter.
// CONFIGURATION
//  PIPE_HAZARD_PERF_EN defined:
//   - Adds outputs stall_cycles[CNT_W] and flush_count[CNT_W].
//   - stall_cycles counts cycles with en_reg_fetch=0 while reset is high.
//   - flush_count counts branch flushes. Both saturate at all-ones and clear on reset.
//  PIPE_HAZARD_PERF_EN not defined: these ports and flops do not exist.
// STRUCTURE
//  - Package pipe_pkg: hz_state_e enum, REG_ZERO=5'd0, default NOP word.
//  - One sub-module, hz_load_use_det: the combinational load-use compare.
//  - FSM, drain counter and output decode stay in this module.
// TESTING
//  - Reset: reset=0 -> en_*=0, flush_*=1, hz_state=0. Release -> all en_*=1 next cycle.
//  - Load-use: ex_mem_r_en=1, ex_wb_en=1, ex_regD=5, id_regA=5 -> one cycle
//    en_reg_fetch=0, injecting_nop=1, inject_nop=NOP_WORD. ex_regD=0 -> no stall.
//  - Branch during I-miss: IC_WAIT, then branch_taken=1 -> flush_decode=flush_alu=1,
//    hz_state=0 next cycle.
//  - DC miss for 4 cycles with simultaneous branch_taken -> all en_*=0, no flush,
//    hz_state=2 for 4 cycles, RUN outputs on the release cycle.
//  - TLB write, TLB_DRAIN_CYCLES=2 -> en_reg_fetch=0 for exactly 2 cycles after the
//    issue cycle. Reset pulse in drain cycle 1 -> hz_state=0 after release.
//  - With PIPE_HAZARD_PERF_EN and CNT_W=4: 20 stall cycles -> stall_cycles=4'hF (saturated).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_pkg;

    // Sequencer states; encodings 4-7 are unused and recover to HZ_RUN.
    typedef enum logic [2:0] {
        HZ_RUN       = 3'd0,
        HZ_IC_WAIT   = 3'd1,
        HZ_DC_WAIT   = 3'd2,
        HZ_TLB_DRAIN = 3'd3
    } hz_state_e;

    localparam logic [4:0]  REG_ZERO         = 5'd0;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    // One bundle of everything the sequencer drives into the pipe each cycle.
    typedef struct packed {
        logic en_fetch;
        logic en_decode;
        logic en_alu;
        logic en_mem;
        logic flush_decode;
        logic flush_alu;
        logic inject;
    } hz_ctrl_t;

    // Normal advance: every stage moves, nothing flushed, fetched word used.
    localparam hz_ctrl_t CTRL_RUN = '{
        en_fetch: 1'b1, en_decode: 1'b1, en_alu: 1'b1, en_mem: 1'b1,
        flush_decode: 1'b0, flush_alu: 1'b0, inject: 1'b0
    };
    // Whole pipe frozen behind the data cache.
    localparam hz_ctrl_t CTRL_FREEZE = '{
        en_fetch: 1'b0, en_decode: 1'b0, en_alu: 1'b0, en_mem: 1'b0,
        flush_decode: 1'b0, flush_alu: 1'b0, inject: 1'b0
    };
    // Fetch held, decode loads a NOP, back end keeps moving.
    localparam hz_ctrl_t CTRL_BUBBLE = '{
        en_fetch: 1'b0, en_decode: 1'b1, en_alu: 1'b1, en_mem: 1'b1,
        flush_decode: 1'b0, flush_alu: 1'b0, inject: 1'b1
    };
    // Taken branch: squash the two wrong-path instructions behind it.
    localparam hz_ctrl_t CTRL_FLUSH = '{
        en_fetch: 1'b1, en_decode: 1'b1, en_alu: 1'b1, en_mem: 1'b1,
        flush_decode: 1'b1, flush_alu: 1'b1, inject: 1'b0
    };
    // Held in reset: nothing advances, front stages cleared.
    localparam hz_ctrl_t CTRL_RESET = '{
        en_fetch: 1'b0, en_decode: 1'b0, en_alu: 1'b0, en_mem: 1'b0,
        flush_decode: 1'b1, flush_alu: 1'b1, inject: 1'b0
    };

endpackage

// File: rtl/hz_load_use_det.sv
// Load-use detector: the ALU-stage load writes a register the decode instruction reads.
module hz_load_use_det
    import pipe_pkg::*;
(
    input  logic       ex_mem_r_en,
    input  logic       ex_wb_en,
    input  logic [4:0] ex_regD,
    input  logic [4:0] id_regA,
    input  logic [4:0] id_regB,
    input  logic       id_uses_regB,
    output logic       load_use
);

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    always_comb begin
        load_use = ex_mem_r_en && ex_wb_en && (ex_regD != REG_ZERO) &&
                   ((ex_regD == id_regA) || (id_uses_regB && (ex_regD == id_regB)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/bubble sequencer for the 5-stage pipe.
// Optional build macro PIPE_HAZARD_PERF_EN adds saturating stall/flush counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] NOP_WORD         = DEFAULT_NOP_WORD,
    parameter int unsigned TLB_DRAIN_CYCLES = 2
`ifdef PIPE_HAZARD_PERF_EN
    ,
    parameter int unsigned CNT_W            = 32
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_regA,
    input  logic [4:0]  id_regB,
    input  logic        id_uses_regB,
    input  logic        id_tlb_write,
    input  logic        ex_mem_r_en,
    input  logic        ex_wb_en,
    input  logic [4:0]  ex_regD,
    input  logic        branch_taken,
    input  logic        block_pipe_instr_cache,
    input  logic        block_pipe_data_cache,
    output logic        en_reg_fetch,
    output logic        en_reg_decode,
    output logic        en_reg_alu,
    output logic        en_reg_mem,
    output logic        flush_decode,
    output logic        flush_alu,
    output logic [31:0] inject_nop,
    output logic        injecting_nop,
    output logic [2:0]  hz_state
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam int unsigned          DRAIN_W    = $clog2(TLB_DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0]   DRAIN_LOAD = DRAIN_W'(TLB_DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0]   DRAIN_ONE  = DRAIN_W'(1);

    hz_state_e          state_q, state_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    hz_ctrl_t           ctrl;
    logic               load_use;

    hz_load_use_det u_load_use (
        .ex_mem_r_en  (ex_mem_r_en),
        .ex_wb_en     (ex_wb_en),
        .ex_regD      (ex_regD),
        .id_regA      (id_regA),
        .id_regB      (id_regB),
        .id_uses_regB (id_uses_regB),
        .load_use     (load_use)
    );

    // Next state, drain count and stage controls from the current state and hazard inputs.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_d     = state_q;
        drain_cnt_d = '0;
        ctrl        = CTRL_RUN;

        if (block_pipe_data_cache) begin
            ctrl    = CTRL_FREEZE;
            state_d = HZ_DC_WAIT;
        end else begin
            case (state_q)
                HZ_RUN: begin
                    if (branch_taken) begin
                        ctrl = CTRL_FLUSH;
                    end else if (id_tlb_write) begin
                        // The TLB write itself advances; fetch is held afterwards.
                        state_d     = HZ_TLB_DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end else if (block_pipe_instr_cache) begin
                        ctrl    = CTRL_BUBBLE;
                        state_d = HZ_IC_WAIT;
                    end else if (load_use) begin
                        // Single bubble; the NOP in decode removes the dependency next cycle.
                        ctrl = CTRL_BUBBLE;
                    end
                end
                HZ_IC_WAIT: begin
                    if (branch_taken) begin
                        // The fetch unit keeps tracking its own outstanding miss.
                        ctrl    = CTRL_FLUSH;
                        state_d = HZ_RUN;
                    end else if (block_pipe_instr_cache) begin
                        ctrl = CTRL_BUBBLE;
                    end else begin
                        state_d = HZ_RUN;
                    end
                end
                HZ_DC_WAIT: begin
                    // Data cache released this cycle: plain advance.
                    state_d = HZ_RUN;
                end
                HZ_TLB_DRAIN: begin
                    ctrl = CTRL_BUBBLE;
                    // <= rather than == so a corrupted zero count cannot stick here.
                    if (drain_cnt_q <= DRAIN_ONE) begin
                        state_d = HZ_RUN;
                    end else begin
                        state_d     = HZ_TLB_DRAIN;
                        drain_cnt_d = drain_cnt_q - DRAIN_ONE;
                    end
                end
                default: begin
                    state_d = HZ_RUN;
                end
            endcase
        end

        if (!reset) begin
            ctrl = CTRL_RESET;
        end
    end

    // State and drain counter; reset aborts any wait or drain immediately.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!reset) begin
            state_q     <= HZ_RUN;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign en_reg_fetch  = ctrl.en_fetch;
    assign en_reg_decode = ctrl.en_decode;
    assign en_reg_alu    = ctrl.en_alu;
    assign en_reg_mem    = ctrl.en_mem;
    assign flush_decode  = ctrl.flush_decode;
    assign flush_alu     = ctrl.flush_alu;
    assign injecting_nop = ctrl.inject;
    assign inject_nop    = NOP_WORD;
    assign hz_state      = state_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    // Saturating increments for held-fetch cycles and branch flushes.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!ctrl.en_fetch && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (ctrl.flush_decode && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    // Counter registers; held at zero while reset is low, so reset cycles never count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model. Honours PIPE_HAZARD_PERF_EN.
module tb_pipe_hazard_ctrl;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DRAIN = 2;
`ifdef PIPE_HAZARD_PERF_EN
    localparam int          CW    = 4;
    localparam int          SAT   = 15;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  id_regA = '0, id_regB = '0, ex_regD = '0;
    logic        id_uses_regB = 1'b0, id_tlb_write = 1'b0;
    logic        ex_mem_r_en = 1'b0, ex_wb_en = 1'b0, branch_taken = 1'b0;
    logic        block_pipe_instr_cache = 1'b0, block_pipe_data_cache = 1'b0;
    logic        en_reg_fetch, en_reg_decode, en_reg_alu, en_reg_mem;
    logic        flush_decode, flush_alu, injecting_nop;
    logic [31:0] inject_nop;
    logic [2:0]  hz_state;
`ifdef PIPE_HAZARD_PERF_EN
    logic [CW-1:0] stall_cycles, flush_count;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .NOP_WORD         (NOP),
        .TLB_DRAIN_CYCLES (DRAIN)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .CNT_W            (CW)
`endif
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .id_regA                (id_regA),
        .id_regB                (id_regB),
        .id_uses_regB           (id_uses_regB),
        .id_tlb_write           (id_tlb_write),
        .ex_mem_r_en            (ex_mem_r_en),
        .ex_wb_en               (ex_wb_en),
        .ex_regD                (ex_regD),
        .branch_taken           (branch_taken),
        .block_pipe_instr_cache (block_pipe_instr_cache),
        .block_pipe_data_cache  (block_pipe_data_cache),
        .en_reg_fetch           (en_reg_fetch),
        .en_reg_decode          (en_reg_decode),
        .en_reg_alu             (en_reg_alu),
        .en_reg_mem             (en_reg_mem),
        .flush_decode           (flush_decode),
        .flush_alu              (flush_alu),
        .inject_nop             (inject_nop),
        .injecting_nop          (injecting_nop),
        .hz_state               (hz_state)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .stall_cycles           (stall_cycles),
        .flush_count            (flush_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: which wait the pipe is in and how many drain cycles remain.
    bit m_dc_wait = 0, m_ic_wait = 0;
    int m_drain = 0;
    bit n_dc_wait, n_ic_wait;
    int n_drain;
    bit e_ef, e_ed, e_ea, e_em, e_fd, e_fa, e_inj;
    int e_st;
    int m_stall = 0, m_flush = 0;

    task automatic set_out(input bit ef, ed, ea, em, fd, fa, inj);
        e_ef = ef; e_ed = ed; e_ea = ea; e_em = em; e_fd = fd; e_fa = fa; e_inj = inj;
    endtask

    // Sample after inputs settle, predict from the rules, compare every output.
    task automatic compare_model();
        bit lu;
        #2;
        if (!reset) begin
            m_dc_wait = 0; m_ic_wait = 0; m_drain = 0; m_stall = 0; m_flush = 0;
        end
        e_st = m_dc_wait ? 2 : m_ic_wait ? 1 : (m_drain > 0) ? 3 : 0;
        n_dc_wait = 0; n_ic_wait = 0; n_drain = 0;
        lu = ex_mem_r_en && ex_wb_en && (ex_regD != 0) &&
             ((ex_regD == id_regA) || (id_uses_regB && (ex_regD == id_regB)));
        set_out(1, 1, 1, 1, 0, 0, 0);
        if (!reset) begin
            set_out(0, 0, 0, 0, 1, 1, 0);
        end else if (block_pipe_data_cache) begin
            set_out(0, 0, 0, 0, 0, 0, 0);
            n_dc_wait = 1;
        end else if (m_dc_wait) begin
            // release cycle: plain advance
        end else if (branch_taken && m_drain == 0) begin
            set_out(1, 1, 1, 1, 1, 1, 0);
        end else if (m_drain > 0) begin
            set_out(0, 1, 1, 1, 0, 0, 1);
            n_drain = m_drain - 1;
        end else if (m_ic_wait) begin
            if (block_pipe_instr_cache) begin
                set_out(0, 1, 1, 1, 0, 0, 1);
                n_ic_wait = 1;
            end
        end else if (id_tlb_write) begin
            n_drain = DRAIN;
        end else if (block_pipe_instr_cache) begin
            set_out(0, 1, 1, 1, 0, 0, 1);
            n_ic_wait = 1;
        end else if (lu) begin
            set_out(0, 1, 1, 1, 0, 0, 1);
        end
        check("en_reg_fetch", en_reg_fetch, e_ef);
        check("en_reg_decode", en_reg_decode, e_ed);
        check("en_reg_alu", en_reg_alu, e_ea);
        check("en_reg_mem", en_reg_mem, e_em);
        check("flush_decode", flush_decode, e_fd);
        check("flush_alu", flush_alu, e_fa);
        check("injecting_nop", injecting_nop, e_inj);
        check("inject_nop", inject_nop, NOP);
        check("hz_state", hz_state, e_st);
`ifdef PIPE_HAZARD_PERF_EN
        check("stall_cycles", stall_cycles, m_stall);
        check("flush_count", flush_count, m_flush);
`endif
    endtask

    // Clock edge: commit the predicted next model state, then return to the negedge.
    task automatic advance();
        @(posedge clk);
        if (reset) begin
            m_dc_wait = n_dc_wait; m_ic_wait = n_ic_wait; m_drain = n_drain;
            if (!e_ef && m_stall < SAT_OR_MAX()) m_stall++;
            if (e_fd && m_flush < SAT_OR_MAX()) m_flush++;
        end
        @(negedge clk);
    endtask

    function automatic int SAT_OR_MAX();
`ifdef PIPE_HAZARD_PERF_EN
        return SAT;
`else
        return 1 << 30;
`endif
    endfunction

    task automatic drive_idle();
        reset = 1'b1;
        id_regA = '0; id_regB = '0; ex_regD = '0;
        id_uses_regB = 1'b0; id_tlb_write = 1'b0;
        ex_mem_r_en = 1'b0; ex_wb_en = 1'b0; branch_taken = 1'b0;
        block_pipe_instr_cache = 1'b0; block_pipe_data_cache = 1'b0;
    endtask

    initial begin
        @(negedge clk);

        // Reset held low, then released.
        reset = 1'b0;
        compare_model();
        check("rst_en_fetch", en_reg_fetch, 1'b0);
        check("rst_en_mem", en_reg_mem, 1'b0);
        check("rst_flush_alu", flush_alu, 1'b1);
        check("rst_state", hz_state, 3'd0);
        advance();
        drive_idle();
        compare_model();
        check("rel_en_fetch", en_reg_fetch, 1'b1);
        check("rel_en_alu", en_reg_alu, 1'b1);
        advance();

        // Load-use on regA, bubble clears it, r0 never stalls, regB needs id_uses_regB.
        ex_mem_r_en = 1'b1; ex_wb_en = 1'b1; ex_regD = 5'd5; id_regA = 5'd5;
        compare_model();
        check("lu_en_fetch", en_reg_fetch, 1'b0);
        check("lu_inject", injecting_nop, 1'b1);
        check("lu_nop_word", inject_nop, 32'h0000_0013);
        advance();
        ex_mem_r_en = 1'b0;
        compare_model();
        check("lu_after_en_fetch", en_reg_fetch, 1'b1);
        advance();
        ex_mem_r_en = 1'b1; ex_regD = 5'd0; id_regA = 5'd0;
        compare_model();
        check("lu_r0_en_fetch", en_reg_fetch, 1'b1);
        advance();
        ex_regD = 5'd7; id_regA = 5'd1; id_regB = 5'd7; id_uses_regB = 1'b0;
        compare_model();
        check("lu_imm_en_fetch", en_reg_fetch, 1'b1);
        advance();
        id_uses_regB = 1'b1;
        compare_model();
        check("lu_regb_en_fetch", en_reg_fetch, 1'b0);
        advance();
        drive_idle();

        // Branch resolves while waiting on the I-cache.
        block_pipe_instr_cache = 1'b1;
        compare_model();
        check("imiss_inject", injecting_nop, 1'b1);
        advance();
        compare_model();
        check("imiss_state", hz_state, 3'd1);
        advance();
        branch_taken = 1'b1;
        compare_model();
        check("br_flush_decode", flush_decode, 1'b1);
        check("br_flush_alu", flush_alu, 1'b1);
        advance();
        drive_idle();
        compare_model();
        check("br_state_after", hz_state, 3'd0);
        advance();

        // D-cache miss for 4 cycles with a branch pending underneath.
        block_pipe_data_cache = 1'b1; branch_taken = 1'b1;
        for (int c = 0; c < 4; c++) begin
            compare_model();
            check("dc_en_fetch", en_reg_fetch, 1'b0);
            check("dc_flush_decode", flush_decode, 1'b0);
            if (c > 0) check("dc_state", hz_state, 3'd2);
            advance();
        end
        drive_idle();
        compare_model();
        check("dc_rel_state", hz_state, 3'd2);
        check("dc_rel_en_decode", en_reg_decode, 1'b1);
        check("dc_rel_inject", injecting_nop, 1'b0);
        advance();
        compare_model();
        check("dc_after_state", hz_state, 3'd0);
        advance();

        // TLB write: issue cycle advances, then exactly two fetch-hold cycles.
        id_tlb_write = 1'b1;
        compare_model();
        check("tlb_issue_en_fetch", en_reg_fetch, 1'b1);
        advance();
        id_tlb_write = 1'b0;
        for (int c = 0; c < 2; c++) begin
            compare_model();
            check("tlb_drain_en_fetch", en_reg_fetch, 1'b0);
            check("tlb_drain_state", hz_state, 3'd3);
            advance();
        end
        compare_model();
        check("tlb_done_en_fetch", en_reg_fetch, 1'b1);
        advance();

        // Reset pulse in drain cycle 1 abandons the drain.
        id_tlb_write = 1'b1;
        compare_model();
        advance();
        id_tlb_write = 1'b0; reset = 1'b0;
        compare_model();
        check("tlb_rst_state", hz_state, 3'd0);
        advance();
        reset = 1'b1;
        compare_model();
        check("tlb_rst_rel_state", hz_state, 3'd0);
        check("tlb_rst_rel_en_fetch", en_reg_fetch, 1'b1);
        advance();

`ifdef PIPE_HAZARD_PERF_EN
        // Counters: one branch flush, then 20 stalled cycles saturate a 4-bit count.
        reset = 1'b0;
        compare_model();
        advance();
        reset = 1'b1; branch_taken = 1'b1;
        compare_model();
        advance();
        branch_taken = 1'b0;
        compare_model();
        check("perf_flush_one", flush_count, 4'd1);
        advance();
        block_pipe_data_cache = 1'b1;
        for (int c = 0; c < 20; c++) begin
            compare_model();
            advance();
        end
        block_pipe_data_cache = 1'b0;
        compare_model();
        check("perf_stall_sat", stall_cycles, 4'hF);
        advance();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit idle;
            idle = !m_dc_wait && !m_ic_wait && (m_drain == 0);
            reset = ($urandom_range(0, 249) != 0);
            block_pipe_data_cache = ($urandom_range(0, 11) == 0) ||
                                    (block_pipe_data_cache && ($urandom_range(0, 3) != 0));
            block_pipe_instr_cache = ($urandom_range(0, 7) == 0) ||
                                     (block_pipe_instr_cache && ($urandom_range(0, 4) != 0));
            branch_taken = ($urandom_range(0, 9) == 0) && (m_drain == 0) &&
                           !(m_dc_wait && !block_pipe_data_cache);
            id_tlb_write = idle && ($urandom_range(0, 11) == 0);
            ex_mem_r_en  = idle && ($urandom_range(0, 1) == 1);
            ex_wb_en     = ($urandom_range(0, 3) != 0);
            ex_regD      = 5'($urandom_range(0, 3));
            id_regA      = 5'($urandom_range(0, 3));
            id_regB      = 5'($urandom_range(0, 3));
            id_uses_regB = ($urandom_range(0, 1) == 1);
            compare_model();
            advance();
        end

        drive_idle();
        for (int c = 0; c < 4; c++) begin
            compare_model();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
